// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: NUM_OBS scrolling obstacle slots with run/freeze FSM, gap/delay spawning and optional speed ramp (OBS_SPEED_RAMP_EN)
module obstacle_scheduler #(
    parameter int NUM_OBS    = 2,
    parameter int CONV       = 2,
    parameter int SPAWN_POS  = 159,
    parameter int MIN_GAP    = 40,
    parameter int SPEED_MAX  = 4,
    parameter int RAMP_TICKS = 600,
    localparam int PW = 10 - CONV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tick,
    input  logic [7:0]            i_rng,
    input  logic                  i_start,
    input  logic                  i_freeze,
    output logic [NUM_OBS*PW-1:0] o_obs_pos,
    output logic [NUM_OBS*3-1:0]  o_obs_type,
    output logic [NUM_OBS-1:0]    o_obs_active,
    output logic [3:0]            o_speed,
    output logic                  o_passed
);
    localparam logic [PW-1:0] GAP_LIM = PW'(SPAWN_POS - MIN_GAP);

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t                state, state_n;
    logic [NUM_OBS*PW-1:0] pos_n;
    logic [NUM_OBS*3-1:0]  type_n;
    logic [NUM_OBS-1:0]    act_n;
    logic [3:0]            speed_n, delay, delay_n;
    logic                  passed_n, gap_ok, spawned;
    logic [PW-1:0]         spd;
    logic                  rng_unused;

    assign rng_unused = i_rng[3];

`ifdef OBS_SPEED_RAMP_EN
    localparam int RW = RAMP_TICKS > 1 ? $clog2(RAMP_TICKS) : 1;
    logic [RW-1:0] ramp, ramp_n;
`else
    localparam int ramp_unused = RAMP_TICKS;
`endif

    // next-state: FSM transitions, slot scrolling, spawn decision and speed ramp
    always_comb begin
        state_n  = state;
        pos_n    = o_obs_pos;
        type_n   = o_obs_type;
        act_n    = o_obs_active;
        speed_n  = o_speed;
        delay_n  = delay;
        passed_n = 1'b0;
        gap_ok   = 1'b1;
        spawned  = 1'b0;
        spd      = PW'(o_speed);
`ifdef OBS_SPEED_RAMP_EN
        ramp_n   = ramp;
`endif
        if (state == RUN && i_freeze) begin
            state_n = FROZEN;
        end else if (state != RUN && i_start) begin
            state_n = RUN;
            pos_n   = '0;
            type_n  = '0;
            act_n   = '0;
            speed_n = 4'd1;
            delay_n = 4'd0;
`ifdef OBS_SPEED_RAMP_EN
            ramp_n  = '0;
`endif
        end else if (state == RUN && i_tick) begin
            for (int k = 0; k < NUM_OBS; k++) begin
                if (o_obs_active[k]) begin
                    if (o_obs_pos[k*PW +: PW] < spd) begin
                        act_n[k] = 1'b0;
                        passed_n = 1'b1;
                    end else begin
                        pos_n[k*PW +: PW] = o_obs_pos[k*PW +: PW] - spd;
                    end
                end
            end
            for (int k = 0; k < NUM_OBS; k++)
                if (act_n[k] && pos_n[k*PW +: PW] > GAP_LIM) gap_ok = 1'b0;
            if (delay != 4'd0) begin
                delay_n = delay - 4'd1;
            end else if (gap_ok) begin
                for (int k = 0; k < NUM_OBS; k++) begin
                    if (!act_n[k] && !spawned) begin
                        spawned           = 1'b1;
                        act_n[k]          = 1'b1;
                        pos_n[k*PW +: PW] = PW'(SPAWN_POS);
                        type_n[k*3 +: 3]  = i_rng[2:0];
                    end
                end
                delay_n = spawned ? i_rng[7:4] : 4'd0;
            end
`ifdef OBS_SPEED_RAMP_EN
            ramp_n = ramp == RW'(RAMP_TICKS - 1) ? '0 : ramp + RW'(1);
            if (ramp == RW'(RAMP_TICKS - 1) && o_speed < 4'(SPEED_MAX)) speed_n = o_speed + 4'd1;
`endif
        end
    end

    // registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_obs_pos    <= '0;
            o_obs_type   <= '0;
            o_obs_active <= '0;
            o_speed      <= 4'd1;
            o_passed     <= 1'b0;
            delay        <= 4'd0;
        end else begin
            state        <= state_n;
            o_obs_pos    <= pos_n;
            o_obs_type   <= type_n;
            o_obs_active <= act_n;
            o_speed      <= speed_n;
            o_passed     <= passed_n;
            delay        <= delay_n;
        end
    end

`ifdef OBS_SPEED_RAMP_EN
    // ramp tick counter
    always_ff @(posedge clk) begin
        if (rst) ramp <= '0;
        else ramp <= ramp_n;
    end
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: scoreboard bench for obstacle_scheduler (ramp checks follow OBS_SPEED_RAMP_EN)
module tb_obstacle_scheduler;
    localparam int N = 2, PW = 8, SP = 159, GAP = 40, SMAX = 2, RT = 4;

    logic          clk = 1'b0;
    logic          rst, i_tick, i_start, i_freeze;
    logic [7:0]    i_rng;
    logic [N*PW-1:0] o_obs_pos;
    logic [N*3-1:0]  o_obs_type;
    logic [N-1:0]    o_obs_active;
    logic [3:0]      o_speed;
    logic            o_passed;

    obstacle_scheduler #(.NUM_OBS(N), .CONV(2), .SPAWN_POS(SP), .MIN_GAP(GAP),
                         .SPEED_MAX(SMAX), .RAMP_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_rng(i_rng), .i_start(i_start),
        .i_freeze(i_freeze), .o_obs_pos(o_obs_pos), .o_obs_type(o_obs_type),
        .o_obs_active(o_obs_active), .o_speed(o_speed), .o_passed(o_passed));

    always #5 clk = ~clk;

    typedef struct {
        logic [N*PW-1:0] pos;
        logic [N*3-1:0]  typ;
        logic [N-1:0]    act;
        logic [3:0]      speed;
        logic            passed;
    } exp_t;

    exp_t q[$];
    int n_checks = 0, n_pass = 0;

    int            m_state, m_ramp;
    logic [PW-1:0] m_pos [N];
    logic [2:0]    m_type [N];
    logic          m_act [N];
    logic [3:0]    m_speed, m_delay;
    logic          m_passed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [N*PW-1:0] pack_pos();
        logic [N*PW-1:0] p;
        for (int k = 0; k < N; k++) p[k*PW +: PW] = m_pos[k];
        return p;
    endfunction

    task automatic model_step();
        bit ok, done;
        m_passed = 1'b0;
        if (rst) begin
            m_state = 0; m_speed = 1; m_delay = 0; m_ramp = 0;
            for (int k = 0; k < N; k++) begin m_pos[k] = 0; m_type[k] = 0; m_act[k] = 0; end
        end else if (m_state == 1 && i_freeze) begin
            m_state = 2;
        end else if (m_state != 1 && i_start) begin
            m_state = 1; m_speed = 1; m_delay = 0; m_ramp = 0;
            for (int k = 0; k < N; k++) begin m_pos[k] = 0; m_type[k] = 0; m_act[k] = 0; end
        end else if (m_state == 1 && i_tick) begin
            for (int k = 0; k < N; k++)
                if (m_act[k]) begin
                    if (m_pos[k] < PW'(m_speed)) begin m_act[k] = 0; m_passed = 1; end
                    else m_pos[k] = m_pos[k] - PW'(m_speed);
                end
            if (m_delay != 0) m_delay = m_delay - 1;
            else begin
                ok = 1; done = 0;
                for (int k = 0; k < N; k++) if (m_act[k] && m_pos[k] > SP - GAP) ok = 0;
                for (int k = 0; k < N; k++)
                    if (ok && !done && !m_act[k]) begin
                        done = 1; m_act[k] = 1; m_pos[k] = SP; m_type[k] = i_rng[2:0];
                    end
                if (done) m_delay = i_rng[7:4];
            end
`ifdef OBS_SPEED_RAMP_EN
            if (m_ramp == RT - 1) begin
                m_ramp = 0;
                if (m_speed < SMAX) m_speed = m_speed + 1;
            end else m_ramp++;
`endif
        end
    endtask

    task automatic cyc(input logic tick, input logic start, input logic freeze, input logic [7:0] rng);
        exp_t e;
        i_tick = tick; i_start = start; i_freeze = freeze; i_rng = rng;
        model_step();
        e.pos = pack_pos(); e.speed = m_speed; e.passed = m_passed;
        for (int k = 0; k < N; k++) begin e.typ[k*3 +: 3] = m_type[k]; e.act[k] = m_act[k]; end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("sb_pos", o_obs_pos, e.pos);
        check("sb_type", o_obs_type, e.typ);
        check("sb_act", o_obs_active, e.act);
        check("sb_speed", o_speed, e.speed);
        check("sb_passed", o_passed, e.passed);
    endtask

    initial begin
        int first;
        bit seen;
        logic [PW-1:0] prev;
        logic [N*PW-1:0] fpos;
        logic [3:0] ramp_exp;
        rst = 1; i_tick = 0; i_start = 0; i_freeze = 0; i_rng = 0;
        cyc(1, 1, 0, 8'h35);
        cyc(1, 0, 0, 8'h35);
        rst = 0;
        check("rst_act", o_obs_active, 0);
        check("rst_speed", o_speed, 1);
        cyc(1, 0, 1, 8'h35);
        check("idle_tick_ignored", o_obs_active, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 8'h35);
        check("spawn_pos", o_obs_pos[PW-1:0], 159);
        check("spawn_type", o_obs_type[2:0], 5);
        check("spawn_act", o_obs_active, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            check("scroll_pos", o_obs_pos[PW-1:0], 158 - i);
            check("scroll_no_spawn", o_obs_active, 2'b01);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        first = 0;
        for (int t = 1; t <= 80 && first == 0; t++) begin
            prev = o_obs_pos[PW-1:0];
            cyc(1, 0, 0, 8'h01);
            if (o_obs_active[1]) begin
                first = t;
                check("gap_pos_le_119", o_obs_pos[PW-1:0] <= 119, 1);
                check("gap_prev_gt_119", prev > 119, 1);
            end
        end
        check("gap_seen", first != 0, 1);
`ifndef OBS_SPEED_RAMP_EN
        check("gap_tick", first, 41);
`endif
        seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
            prev = o_obs_pos[PW-1:0];
            cyc(1, 0, 0, 8'h01);
            seen = o_passed;
        end
        check("exit_seen", seen, 1);
`ifndef OBS_SPEED_RAMP_EN
        check("exit_prev_pos0", prev, 0);
`endif
        check("exit_slot0_left", o_obs_active[0] == 1'b0 || o_obs_pos[PW-1:0] == 159, 1);
        cyc(1, 0, 0, 8'h01);
        check("exit_pulse_once", o_passed, 0);
        cyc(0, 1, 1, 0);
        fpos = pack_pos();
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'h01);
        check("frz_hold", o_obs_pos, fpos);
        cyc(0, 1, 0, 0);
        check("restart_act", o_obs_active, 0);
        check("restart_pos", o_obs_pos, 0);
        check("restart_speed", o_speed, 1);
`ifdef OBS_SPEED_RAMP_EN
        ramp_exp = 2;
`else
        ramp_exp = 1;
`endif
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h20);
        check("ramp_4", o_speed, ramp_exp);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h20);
        check("ramp_8", o_speed, ramp_exp);
        rst = 1;
        cyc(1, 0, 0, 8'h35);
        cyc(1, 1, 0, 8'h35);
        rst = 0;
        check("midrst_act", o_obs_active, 0);
        check("midrst_pos", o_obs_pos, 0);
        check("midrst_speed", o_speed, 1);
        check("midrst_passed", o_passed, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'h35);
        check("midrst_ticks_ignored", o_obs_active, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
